// File: rtl/DataTypes.sv
// Shared types for the FIFO pointer/flag controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: bit_t scalar, DEFAULT_DEPTH, fifo_flags_t status bundle.
package DataTypes;

    typedef logic bit_t;

    localparam int DEFAULT_DEPTH = 16;

    // Registered status bits of the controller, kept together so reset and
    // next-state logic treat them as one register.
    typedef struct packed {
        bit_t full;
        bit_t empty;
        bit_t almost_full;
        bit_t almost_empty;
        bit_t overflow;
        bit_t underflow;
    } fifo_flags_t;

endpackage

// File: rtl/wrap_ptr.sv
// Modulo-DEPTH address pointer; wraps DEPTH-1 -> 0 for any DEPTH >= 2.
// Latency: ptr advances on the clk edge where inc is high, visible next cycle.
// Backpressure: none; the caller only raises inc for accepted transfers.
// Ports: clk, reset (async active-low), inc (advance), ptr (current address).
module wrap_ptr #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          inc,
    output logic [AW-1:0] ptr
);

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr <= '0;
        end else if (inc) begin
            // Explicit compare, not natural overflow, so non-power-of-two
            // depths wrap at the right place.
            ptr <= (ptr == LAST) ? '0 : ptr + AW'(1);
        end
    end

endmodule

// File: rtl/fifo_ptr_ctrl.sv
// Pointer, occupancy and flag controller for a single-clock FIFO over a dual-port RAM.
// Latency: w_en/r_en/addresses valid in the request cycle; count/flags update on that edge.
// Backpressure: push rejected while full, pop rejected while empty; each sets a sticky error.
// Ports: clk, reset (async active-low), push, pop, clr_err in; w_add/w_en, r_add/r_en to RAM;
//        count, full, empty, almost_full, almost_empty, overflow, underflow status out.
module fifo_ptr_ctrl
    import DataTypes::*;
#(
    parameter  int DEPTH    = DEFAULT_DEPTH,
    parameter  int AF_LEVEL = DEPTH - 2,
    parameter  int AE_LEVEL = 2,
    localparam int AW       = $clog2(DEPTH),
    localparam int CW       = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic          clr_err,
    output logic [AW-1:0] w_add,
    output logic          w_en,
    output logic [AW-1:0] r_add,
    output logic          r_en,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty,
    output logic          almost_full,
    output logic          almost_empty,
    output logic          overflow,
    output logic          underflow
);

    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C   = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_C   = CW'(AE_LEVEL);

    fifo_flags_t   flg;
    fifo_flags_t   flg_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    bit_t          wr_acc;
    bit_t          rd_acc;

    // Accept decisions use the registered flags only, so a simultaneous pop
    // never frees a slot for a push at full (and vice versa at empty).
    // Gating with reset keeps the RAM enables quiet while reset is held.
    assign wr_acc = push & ~flg.full  & reset;
    assign rd_acc = pop  & ~flg.empty & reset;

    assign w_en = wr_acc;
    assign r_en = rd_acc;

    wrap_ptr #(.DEPTH(DEPTH), .AW(AW)) u_wr_ptr (
        .clk   (clk),
        .reset (reset),
        .inc   (wr_acc),
        .ptr   (w_add)
    );

    wrap_ptr #(.DEPTH(DEPTH), .AW(AW)) u_rd_ptr (
        .clk   (clk),
        .reset (reset),
        .inc   (rd_acc),
        .ptr   (r_add)
    );

    always_comb begin
        cnt_nxt = cnt;
        if (wr_acc && !rd_acc) begin
            cnt_nxt = cnt + CW'(1);
        end else if (rd_acc && !wr_acc) begin
            cnt_nxt = cnt - CW'(1);
        end
    end

    // Flags come from the next count so they line up with count every cycle.
    // A new error event outranks clr_err in the same cycle.
    always_comb begin
        flg_nxt              = flg;
        flg_nxt.full         = (cnt_nxt == FULL_C);
        flg_nxt.empty        = (cnt_nxt == '0);
        flg_nxt.almost_full  = (cnt_nxt >= AF_C);
        flg_nxt.almost_empty = (cnt_nxt <= AE_C);
        flg_nxt.overflow     = (push & flg.full)  | (flg.overflow  & ~clr_err);
        flg_nxt.underflow    = (pop  & flg.empty) | (flg.underflow & ~clr_err);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
            flg <= '{full: 1'b0, empty: 1'b1, almost_full: 1'b0, almost_empty: 1'b1,
                     overflow: 1'b0, underflow: 1'b0};
        end else begin
            cnt <= cnt_nxt;
            flg <= flg_nxt;
        end
    end

    assign count        = cnt;
    assign full         = flg.full;
    assign empty        = flg.empty;
    assign almost_full  = flg.almost_full;
    assign almost_empty = flg.almost_empty;
    assign overflow     = flg.overflow;
    assign underflow    = flg.underflow;

endmodule

// File: tb/tb_fifo_ptr_ctrl.sv
// Directed bench for fifo_ptr_ctrl: DEPTH=16 instance and a DEPTH=5 wrap instance.
// Inputs change on the falling edge; combinational outputs are sampled 1ns later,
// registered outputs 1ns after the rising edge.
module tb_fifo_ptr_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // DEPTH = 16 instance
    logic       rst16, push16, pop16, clr16;
    logic [3:0] wadd16, radd16;
    logic       wen16, ren16;
    logic [4:0] cnt16;
    logic       full16, empty16, af16, ae16, ovf16, unf16;

    fifo_ptr_ctrl #(.DEPTH(16)) u_d16 (
        .clk          (clk),
        .reset        (rst16),
        .push         (push16),
        .pop          (pop16),
        .clr_err      (clr16),
        .w_add        (wadd16),
        .w_en         (wen16),
        .r_add        (radd16),
        .r_en         (ren16),
        .count        (cnt16),
        .full         (full16),
        .empty        (empty16),
        .almost_full  (af16),
        .almost_empty (ae16),
        .overflow     (ovf16),
        .underflow    (unf16)
    );

    // DEPTH = 5 instance (non-power-of-two wrap)
    logic       rst5, push5, pop5, clr5;
    logic [2:0] wadd5, radd5;
    logic       wen5, ren5;
    logic [2:0] cnt5;
    logic       full5, empty5, af5, ae5, ovf5, unf5;

    fifo_ptr_ctrl #(.DEPTH(5)) u_d5 (
        .clk          (clk),
        .reset        (rst5),
        .push         (push5),
        .pop          (pop5),
        .clr_err      (clr5),
        .w_add        (wadd5),
        .w_en         (wen5),
        .r_add        (radd5),
        .r_en         (ren5),
        .count        (cnt5),
        .full         (full5),
        .empty        (empty5),
        .almost_full  (af5),
        .almost_empty (ae5),
        .overflow     (ovf5),
        .underflow    (unf5)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Apply D16 request inputs on the falling edge, settle combinational outputs.
    task automatic drv16(input logic p, input logic q, input logic c);
        @(negedge clk);
        push16 = p;
        pop16  = q;
        clr16  = c;
        #1;
    endtask

    task automatic drv5(input logic p, input logic q);
        @(negedge clk);
        push5 = p;
        pop5  = q;
        #1;
    endtask

    // Let the rising edge happen, then settle registered outputs.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst16 = 1'b0; push16 = 1'b1; pop16 = 1'b1; clr16 = 1'b0;
        rst5  = 1'b0; push5  = 1'b0; pop5  = 1'b0; clr5  = 1'b0;

        // Reset state, with requests asserted to show they are ignored.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_w_add", wadd16, 0);
        chk("rst_r_add", radd16, 0);
        chk("rst_count", cnt16, 0);
        chk("rst_empty", empty16, 1);
        chk("rst_almost_empty", ae16, 1);
        chk("rst_full", full16, 0);
        chk("rst_almost_full", af16, 0);
        chk("rst_overflow", ovf16, 0);
        chk("rst_underflow", unf16, 0);
        chk("rst_w_en", wen16, 0);
        chk("rst_r_en", ren16, 0);

        @(negedge clk);
        push16 = 1'b0; pop16 = 1'b0;
        rst16 = 1'b1; rst5 = 1'b1;

        // Idle after reset release: nothing moves.
        tick();
        chk("idle_count", cnt16, 0);
        chk("idle_w_en", wen16, 0);

        // 16 back-to-back pushes.
        for (int i = 0; i < 16; i++) begin
            drv16(1'b1, 1'b0, 1'b0);
            chk($sformatf("fill_w_en_%0d", i), wen16, 1);
            chk($sformatf("fill_w_add_%0d", i), wadd16, i);
            tick();
            chk($sformatf("fill_count_%0d", i), cnt16, i + 1);
            chk($sformatf("fill_af_%0d", i), af16, (i + 1 >= 14) ? 1 : 0);
        end
        chk("full_after_16", full16, 1);
        chk("empty_after_16", empty16, 0);
        chk("wptr_wrapped", wadd16, 0);

        // 17th push is rejected.
        drv16(1'b1, 1'b0, 1'b0);
        chk("push17_w_en", wen16, 0);
        tick();
        chk("push17_overflow", ovf16, 1);
        chk("push17_count", cnt16, 16);

        // Push+pop while full: only the read is accepted.
        drv16(1'b1, 1'b1, 1'b0);
        chk("pp_full_r_en", ren16, 1);
        chk("pp_full_w_en", wen16, 0);
        chk("pp_full_r_add", radd16, 0);
        tick();
        chk("pp_full_count", cnt16, 15);
        chk("pp_full_overflow", ovf16, 1);
        chk("pp_full_r_add_next", radd16, 1);
        chk("pp_full_full", full16, 0);

        drv16(1'b0, 1'b0, 1'b1);
        tick();
        chk("clr_overflow", ovf16, 0);

        // Pop 8 to reach count 7.
        for (int i = 0; i < 8; i++) begin
            drv16(1'b0, 1'b1, 1'b0);
            tick();
        end
        chk("mid_count7", cnt16, 7);
        chk("mid_r_add", radd16, 9);

        // Asynchronous reset mid-stream, between clock edges.
        drv16(1'b1, 1'b0, 1'b0);
        rst16 = 1'b0;
        #1;
        chk("async_count", cnt16, 0);
        chk("async_w_add", wadd16, 0);
        chk("async_r_add", radd16, 0);
        chk("async_empty", empty16, 1);
        chk("async_w_en", wen16, 0);
        @(negedge clk);
        rst16 = 1'b1;
        #1;
        chk("post_rst_w_en", wen16, 1);
        chk("post_rst_w_add", wadd16, 0);
        tick();
        chk("post_rst_count", cnt16, 1);

        // Two more pushes to count 3, then simultaneous push+pop.
        for (int i = 0; i < 2; i++) begin
            drv16(1'b1, 1'b0, 1'b0);
            tick();
        end
        drv16(1'b1, 1'b1, 1'b0);
        chk("pp3_w_en", wen16, 1);
        chk("pp3_r_en", ren16, 1);
        chk("pp3_w_add", wadd16, 3);
        chk("pp3_r_add", radd16, 0);
        tick();
        chk("pp3_count", cnt16, 3);
        chk("pp3_w_add_next", wadd16, 4);
        chk("pp3_r_add_next", radd16, 1);

        // Drain to empty, then push+pop while empty: only the write is accepted.
        for (int i = 0; i < 3; i++) begin
            drv16(1'b0, 1'b1, 1'b0);
            tick();
        end
        chk("drain_empty", empty16, 1);
        chk("drain_underflow", unf16, 0);
        drv16(1'b1, 1'b1, 1'b0);
        chk("ppe_w_en", wen16, 1);
        chk("ppe_r_en", ren16, 0);
        tick();
        chk("ppe_count", cnt16, 1);
        chk("ppe_underflow", unf16, 1);
        chk("ppe_empty", empty16, 0);
        drv16(1'b0, 1'b1, 1'b0);
        tick();
        chk("ppe_drain_count", cnt16, 0);

        // Error clearing, and new event beating clr_err.
        drv16(1'b0, 1'b0, 1'b1);
        tick();
        chk("clr_underflow", unf16, 0);
        drv16(1'b0, 1'b1, 1'b0);
        chk("uf_pop_r_en", ren16, 0);
        tick();
        chk("uf_set_again", unf16, 1);
        chk("uf_count", cnt16, 0);
        drv16(1'b0, 1'b1, 1'b1);
        tick();
        chk("uf_clr_and_event", unf16, 1);
        drv16(1'b0, 1'b0, 1'b1);
        tick();
        chk("uf_clr_final", unf16, 0);
        drv16(1'b0, 1'b0, 1'b0);

        // DEPTH=5 wrap: push 5, pop 5, twice.
        for (int rep = 0; rep < 2; rep++) begin
            for (int i = 0; i < 5; i++) begin
                drv5(1'b1, 1'b0);
                chk($sformatf("d5_w_en_%0d_%0d", rep, i), wen5, 1);
                chk($sformatf("d5_w_add_%0d_%0d", rep, i), wadd5, i);
                tick();
            end
            chk($sformatf("d5_full_%0d", rep), full5, 1);
            chk($sformatf("d5_count_full_%0d", rep), cnt5, 5);
            for (int i = 0; i < 5; i++) begin
                drv5(1'b0, 1'b1);
                chk($sformatf("d5_r_en_%0d_%0d", rep, i), ren5, 1);
                chk($sformatf("d5_r_add_%0d_%0d", rep, i), radd5, i);
                tick();
            end
        end
        drv5(1'b0, 1'b0);
        chk("d5_empty_end", empty5, 1);
        chk("d5_count_end", cnt5, 0);
        chk("d5_overflow_end", ovf5, 0);
        chk("d5_underflow_end", unf5, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
